// File: rtl/ce_pkg.sv
// ce_pkg -- shared definitions for the channel-estimation LS sequencer.
//   CE_MAX_UE        : UEs that can be sequenced in one RS symbol
//   CE_*_MIN/MAX     : legal ranges for the per-symbol configuration
//   ce_state_e       : sequencer FSM encoding
//   ce_cfg_legal()   : range check applied to a start request
package ce_pkg;

  localparam int CE_MAX_UE     = 4;
  localparam int CE_NUM_UE_MIN = 1;
  localparam int CE_NUM_RX_MIN = 1;
  localparam int CE_NUM_RX_MAX = 2;
  localparam int CE_LEN_MIN    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ce_state_e;

  // Upper length bound is the buffer depth, 2^w_addr subcarriers.
  function automatic logic ce_cfg_legal(input logic [2:0]  num_ue,
                                        input logic [1:0]  num_rx,
                                        input logic [11:0] len,
                                        input int          max_ue,
                                        input int          w_addr);
    return (int'(num_ue) >= CE_NUM_UE_MIN) && (int'(num_ue) <= max_ue) &&
           (int'(num_rx) >= CE_NUM_RX_MIN) && (int'(num_rx) <= CE_NUM_RX_MAX) &&
           (int'(len) >= CE_LEN_MIN) && (int'(len) <= (1 << w_addr));
  endfunction

endpackage

// File: rtl/ce_ls_ctrl_addr_gen.sv
// ce_ls_ctrl_addr_gen -- subcarrier address, pass, UE and antenna counters.
//   clk, rst_n_sync : clock, synchronous active-low reset
//   clear           : restart counters at an accepted start
//   run             : sequencer is issuing reads
//   ready           : LS datapath ready; gates every read
//   num_rx_m1       : 1 when two antennas are configured
//   len_m1          : last address of a pass
//   last_pass       : index of the final pass (num_ue*num_rx-1)
//   buf_rd_en/addr  : buffer read strobe and address (stage p0)
//   ls_valid/sop/eop, ue_idx, buf_ant : framing aligned to read data (stage p1)
//   last_issue      : final sample of final pass is being read this cycle
module ce_ls_ctrl_addr_gen
  import ce_pkg::*;
#(
  parameter int wAddr = 11
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             clear,
  input  logic             run,
  input  logic             ready,
  input  logic             num_rx_m1,
  input  logic [wAddr:0]   len_m1,
  input  logic [2:0]       last_pass,
  output logic             buf_rd_en,
  output logic [wAddr-1:0] buf_rd_addr,
  output logic             ls_valid,
  output logic             ls_sop,
  output logic             ls_eop,
  output logic [1:0]       ue_idx,
  output logic             buf_ant,
  output logic             last_issue
);

  logic [wAddr:0] addr_p0;
  logic [2:0]     pass_p0;
  logic [1:0]     ue_p0;
  logic           ant_p0;
  logic           rd_en_p0;
  logic           pass_end_p0;

  logic           vld_p1;
  logic           sop_p1;
  logic           eop_p1;
  logic [1:0]     ue_p1;
  logic           ant_p1;

  // ---- stage p0: read request to the subcarrier buffer ----
  assign rd_en_p0    = run & ready;
  assign pass_end_p0 = (addr_p0 == len_m1);
  assign last_issue  = rd_en_p0 & pass_end_p0 & (pass_p0 == last_pass);

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      addr_p0 <= '0;
      pass_p0 <= '0;
      ue_p0   <= '0;
      ant_p0  <= 1'b0;
    end else if (clear) begin
      addr_p0 <= '0;
      pass_p0 <= '0;
      ue_p0   <= '0;
      ant_p0  <= 1'b0;
    end else if (rd_en_p0) begin
      if (pass_end_p0) begin
        // Antenna is the inner loop: UE only moves once all antennas are done.
        addr_p0 <= '0;
        pass_p0 <= pass_p0 + 3'd1;
        if (ant_p0 == num_rx_m1) begin
          ant_p0 <= 1'b0;
          ue_p0  <= ue_p0 + 2'd1;
        end else begin
          ant_p0 <= 1'b1;
        end
      end else begin
        addr_p0 <= addr_p0 + 1'b1;
      end
    end
  end

  // ---- stage p1: framing aligned with buffer read data ----
  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      vld_p1 <= 1'b0;
      sop_p1 <= 1'b0;
      eop_p1 <= 1'b0;
      ue_p1  <= '0;
      ant_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en_p0;
      sop_p1 <= rd_en_p0 & (addr_p0 == '0);
      eop_p1 <= rd_en_p0 & pass_end_p0;
      // Held through stalls so the pass identity stays with its samples.
      if (rd_en_p0) begin
        ue_p1  <= ue_p0;
        ant_p1 <= ant_p0;
      end
    end
  end

  assign buf_rd_en   = rd_en_p0;
  assign buf_rd_addr = addr_p0[wAddr-1:0];
  assign ls_valid    = vld_p1;
  assign ls_sop      = sop_p1;
  assign ls_eop      = eop_p1;
  assign ue_idx      = ue_p1;
  assign buf_ant     = ant_p1;

endmodule

// File: rtl/ce_ls_ctrl.sv
// ce_ls_ctrl -- sequences LS channel-estimation passes for one RS symbol.
//   clk, rst_n_sync        : clock, synchronous active-low reset
//   start, num_ue, num_rx, len : request and per-symbol configuration
//   buf_rd_en/addr, buf_ant: subcarrier buffer read port
//   ue_idx                 : UE index to the RS-tx coefficient generator
//   ls_sink_ready          : backpressure from the LS datapath
//   ls_valid/sop/eop       : stream framing to the LS datapath
//   ls_source_valid/eop    : LS output framing, used to detect drain
//   busy, done, err        : status (done/err are one-cycle pulses)
module ce_ls_ctrl
  import ce_pkg::*;
#(
  parameter int wAddr  = 11,
  parameter int MAX_UE = CE_MAX_UE
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             start,
  input  logic [2:0]       num_ue,
  input  logic [1:0]       num_rx,
  input  logic [11:0]      len,
  output logic             buf_rd_en,
  output logic [wAddr-1:0] buf_rd_addr,
  output logic             buf_ant,
  output logic [1:0]       ue_idx,
  input  logic             ls_sink_ready,
  output logic             ls_valid,
  output logic             ls_sop,
  output logic             ls_eop,
  input  logic             ls_source_valid,
  input  logic             ls_source_eop,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = wAddr + 1;

  ce_state_e      state_q, state_d;
  logic [2:0]     num_ue_q;
  logic [1:0]     num_rx_q;
  logic [11:0]    len_q;
  logic [3:0]     eop_cnt_q;
  logic           err_q;
  logic           done_q;

  logic           start_ok;
  logic           last_issue;
  logic           eop_hit;
  logic           drain_fin;
  logic [3:0]     total_passes;
  logic [AW-1:0]  len_m1;
  logic [2:0]     last_pass;
  logic           num_rx_m1;

  assign start_ok     = start && (state_q == ST_IDLE) &&
                        ce_cfg_legal(num_ue, num_rx, len, MAX_UE, wAddr);
  assign total_passes = 4'(num_ue_q) * 4'(num_rx_q);
  assign last_pass    = 3'(total_passes - 4'd1);
  assign len_m1       = AW'(len_q - 12'd1);
  assign num_rx_m1    = (num_rx_q == 2'd2);

  // Eops are counted from acceptance, so a fast LS path that returns eops
  // while still in RUN is handled; >= lets DRAIN finish on entry in that case.
  assign eop_hit   = (state_q != ST_IDLE) && ls_source_valid && ls_source_eop;
  assign drain_fin = (state_q == ST_DRAIN) &&
                     (({1'b0, eop_cnt_q} + {4'd0, eop_hit}) >= {1'b0, total_passes});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok)   state_d = ST_RUN;
      ST_RUN:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_fin)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state_q   <= ST_IDLE;
      num_ue_q  <= '0;
      num_rx_q  <= '0;
      len_q     <= '0;
      eop_cnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start && !start_ok;
      done_q  <= drain_fin;
      if (start_ok) begin
        num_ue_q  <= num_ue;
        num_rx_q  <= num_rx;
        len_q     <= len;
        eop_cnt_q <= '0;
      end else if (eop_hit) begin
        eop_cnt_q <= eop_cnt_q + 4'd1;
      end
    end
  end

  ce_ls_ctrl_addr_gen #(
    .wAddr (wAddr)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n_sync  (rst_n_sync),
    .clear       (start_ok),
    .run         (state_q == ST_RUN),
    .ready       (ls_sink_ready),
    .num_rx_m1   (num_rx_m1),
    .len_m1      (len_m1),
    .last_pass   (last_pass),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .ls_valid    (ls_valid),
    .ls_sop      (ls_sop),
    .ls_eop      (ls_eop),
    .ue_idx      (ue_idx),
    .buf_ant     (buf_ant),
    .last_issue  (last_issue)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ce_ls_ctrl.sv
module tb_ce_ls_ctrl;

  localparam int W_ADDR = 11;

  logic              clk = 1'b0;
  logic              rst_n_sync;
  logic              start;
  logic [2:0]        num_ue;
  logic [1:0]        num_rx;
  logic [11:0]       len;
  logic              buf_rd_en;
  logic [W_ADDR-1:0] buf_rd_addr;
  logic              buf_ant;
  logic [1:0]        ue_idx;
  logic              ls_sink_ready;
  logic              ls_valid, ls_sop, ls_eop;
  logic              ls_source_valid, ls_source_eop;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ce_ls_ctrl #(.wAddr(W_ADDR), .MAX_UE(4)) dut (
    .clk             (clk),
    .rst_n_sync      (rst_n_sync),
    .start           (start),
    .num_ue          (num_ue),
    .num_rx          (num_rx),
    .len             (len),
    .buf_rd_en       (buf_rd_en),
    .buf_rd_addr     (buf_rd_addr),
    .buf_ant         (buf_ant),
    .ue_idx          (ue_idx),
    .ls_sink_ready   (ls_sink_ready),
    .ls_valid        (ls_valid),
    .ls_sop          (ls_sop),
    .ls_eop          (ls_eop),
    .ls_source_valid (ls_source_valid),
    .ls_source_eop   (ls_source_eop),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the expected sample stream is the nested loop
  // for ue, for ant, for addr; the LS datapath is a pure delay of lat cycles.
  task automatic run_seq(input string name, input int nue, input int nrx, input int ln,
                         input int lat, input int rdy_pct, input int stall_at, input int inj_at);
    int total, tsamp, issued, srccnt, k, done_cyc, stall_left, vcnt, code, pass_i, idx, obs_code;
    bit rden_prev, err_next, exp_rden, exp_done, exp_busy, rdy, sv, se;
    int exp_q[$];
    logic [1:0] obs [16];
    total = nue * nrx;
    tsamp = total * ln;
    issued = 0; srccnt = 0; done_cyc = -1; stall_left = 3; vcnt = 0;
    rden_prev = 1'b0; err_next = 1'b0;
    for (int i = 0; i < 16; i++) obs[i] = 2'b00;
    start = 1'b1; num_ue = 3'(nue); num_rx = 2'(nrx); len = 12'(ln);
    ls_sink_ready = 1'b0; ls_source_valid = 1'b0; ls_source_eop = 1'b0;
    step;
    k = 1;
    start = 1'b0;
    num_ue = 3'($urandom_range(0, 7)); num_rx = 2'($urandom_range(0, 3)); len = 12'($urandom);
    forever begin
      checks++;
      if (ls_valid !== rden_prev) begin
        errors++;
        $display("FAIL %s ls_valid cyc %0d got %b want %b", name, k, ls_valid, rden_prev);
      end
      if (rden_prev && exp_q.size() > 0) begin
        vcnt++;
        code = exp_q.pop_front();
        obs_code = int'({ue_idx, buf_ant, ls_sop, ls_eop});
        checks++;
        if (obs_code !== code) begin
          errors++;
          $display("FAIL %s frame cyc %0d got ue/ant/sop/eop=%0d want %0d", name, k, obs_code, code);
        end
      end
      exp_done = (k == done_cyc);
      exp_busy = (done_cyc < 0) || (k < done_cyc);
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("FAIL %s done/busy cyc %0d got %b/%b want %b/%b", name, k, done, busy, exp_done, exp_busy);
      end
      checks++;
      if (err !== err_next) begin
        errors++;
        $display("FAIL %s err cyc %0d got %b want %b", name, k, err, err_next);
      end
      err_next = 1'b0;
      if (k == done_cyc) break;
      if (k > 8 * tsamp + 300) begin
        checks++; errors++;
        $display("FAIL %s timeout at cyc %0d issued %0d eops %0d", name, k, issued, srccnt);
        break;
      end
      // LS datapath loopback: source framing is the observed ls framing lat cycles later.
      obs[k % 16] = {ls_valid, ls_eop};
      if (k - lat >= 1) {sv, se} = obs[(k - lat) % 16];
      else {sv, se} = 2'b00;
      ls_source_valid = sv;
      ls_source_eop   = sv ? se : 1'($urandom_range(0, 1));
      if (sv && se) begin
        srccnt++;
        if (srccnt == total) done_cyc = k + 1;
      end
      if (issued == stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 99) < rdy_pct);
      end
      ls_sink_ready = rdy;
      if (k == inj_at) begin
        start = 1'b1;
        num_ue = 3'($urandom_range(1, 4)); num_rx = 2'($urandom_range(1, 2));
        err_next = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      exp_rden = rdy && (issued < tsamp);
      checks++;
      if (buf_rd_en !== exp_rden) begin
        errors++;
        $display("FAIL %s buf_rd_en cyc %0d got %b want %b", name, k, buf_rd_en, exp_rden);
      end
      if (issued < tsamp) begin
        checks++;
        if (buf_rd_addr !== W_ADDR'(issued % ln)) begin
          errors++;
          $display("FAIL %s buf_rd_addr cyc %0d got %0d want %0d", name, k, buf_rd_addr, issued % ln);
        end
      end
      if (exp_rden) begin
        pass_i = issued / ln;
        idx    = issued % ln;
        exp_q.push_back((pass_i / nrx) * 8 + (pass_i % nrx) * 4 +
                        ((idx == 0) ? 2 : 0) + ((idx == ln - 1) ? 1 : 0));
        issued++;
      end
      rden_prev = exp_rden;
      step;
      k++;
    end
    start = 1'b0; ls_sink_ready = 1'b0; ls_source_valid = 1'b0; ls_source_eop = 1'b0;
    checks++;
    if (vcnt != tsamp) begin
      errors++;
      $display("FAIL %s valid_count got %0d want %0d", name, vcnt, tsamp);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({buf_rd_en, ls_valid, ls_sop, ls_eop, busy, done, err} !== 7'b0) begin
      errors++;
      $display("FAIL %s ctrl got %b want 0000000", name,
               {buf_rd_en, ls_valid, ls_sop, ls_eop, busy, done, err});
    end
    checks++;
    if (buf_rd_addr !== '0 || buf_ant !== 1'b0 || ue_idx !== 2'b0) begin
      errors++;
      $display("FAIL %s addr/ant/ue got %0d/%b/%0d want 0/0/0", name, buf_rd_addr, buf_ant, ue_idx);
    end
  endtask

  task automatic test_reset;
    rst_n_sync = 1'b0; start = 1'b0; num_ue = 3'd1; num_rx = 2'd1; len = 12'd12;
    ls_sink_ready = 1'b1; ls_source_valid = 1'b0; ls_source_eop = 1'b0;
    step; step;
    check_all_zero("reset");
    rst_n_sync = 1'b1; ls_sink_ready = 1'b0;
    step;
  endtask

  task automatic test_illegal;
    int cfg [5][3];
    cfg = '{'{0, 1, 12}, '{1, 3, 12}, '{1, 1, 1}, '{5, 2, 8}, '{2, 0, 2049}};
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; num_ue = 3'(cfg[i][0]); num_rx = 2'(cfg[i][1]); len = 12'(cfg[i][2]);
      ls_sink_ready = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || buf_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d err/busy/rd got %b/%b/%b want 1/0/0", i, err, busy, buf_rd_en);
      end
      step;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d_after err/busy got %b/%b want 0/0", i, err, busy);
      end
    end
    ls_sink_ready = 1'b0;
  endtask

  task automatic test_idle_eop;
    ls_source_valid = 1'b1; ls_source_eop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_eop busy/done got %b/%b want 0/0", busy, done);
      end
    end
    ls_source_valid = 1'b0; ls_source_eop = 1'b0;
    run_seq("idle_eop_run", 1, 2, 4, 3, 100, -1, -1);
  endtask

  task automatic test_reset_mid;
    start = 1'b1; num_ue = 3'd2; num_rx = 2'd2; len = 12'd8;
    ls_sink_ready = 1'b1; ls_source_valid = 1'b0; ls_source_eop = 1'b0;
    step;
    start = 1'b0;
    repeat (10) step;
    rst_n_sync = 1'b0;
    step;
    check_all_zero("reset_mid");
    rst_n_sync = 1'b1; ls_sink_ready = 1'b0;
    step;
    run_seq("post_reset", 2, 2, 8, 1, 100, -1, -1);
  endtask

  task automatic test_random;
    int nue, nrx, ln;
    for (int i = 0; i < 8; i++) begin
      nue = $urandom_range(1, 4);
      nrx = $urandom_range(1, 2);
      ln  = $urandom_range(2, 40);
      run_seq($sformatf("random_%0d", i), nue, nrx, ln, $urandom_range(0, 5),
              $urandom_range(40, 100), $urandom_range(0, nue * nrx * ln - 1),
              $urandom_range(2, 20));
      repeat ($urandom_range(0, 3)) step;
    end
  endtask

  initial begin
    test_reset;
    run_seq("single_len12", 1, 1, 12, 0, 100, -1, -1);
    run_seq("multi_2x2_len4", 2, 2, 4, 0, 100, -1, -1);
    run_seq("stall_2x2_len4", 2, 2, 4, 2, 100, 6, -1);
    test_illegal;
    run_seq("start_busy", 2, 2, 8, 1, 100, -1, 5);
    test_reset_mid;
    test_idle_eop;
    run_seq("len_min_max_passes", 4, 2, 2, 2, 100, -1, -1);
    run_seq("len_max", 1, 1, 2048, 1, 100, -1, -1);
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ce_ls_ctrl.md
CE_LS_CTRL -- requirements
Module: ce_ls_ctrl

Interface
REQ-001 SHALL have parameter wAddr, default 11, width of subcarrier-buffer read address.
REQ-002 SHALL have parameter MAX_UE, default 4, maximum UEs sequenced per symbol.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n_sync  input  1  reset, synchronous to clk, active-low.
REQ-005 start  input  1  one-cycle pulse: begin LS sequence for one RS symbol.
REQ-006 num_ue  input  3  UEs this symbol, legal 1..MAX_UE.
REQ-007 num_rx  input  2  RX antennas this symbol, legal 1..2.
REQ-008 len  input  12  subcarriers per pass, legal 2..2^wAddr.
REQ-009 buf_rd_en  output  1  read strobe to RX subcarrier buffer.
REQ-010 buf_rd_addr  output  wAddr  buffer read address.
REQ-011 buf_ant  output  1  RX antenna select for buffer read.
REQ-012 ue_idx  output  2  UE index to RS-tx coefficient generator.
REQ-013 ls_sink_ready  input  1  ready from LS datapath.
REQ-014 ls_valid, ls_sop, ls_eop  output  1 each  stream framing to LS datapath.
REQ-015 ls_source_valid, ls_source_eop  input  1 each  LS output framing, for drain tracking.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse, all passes drained.
REQ-018 err  output  1  one-cycle pulse on rejected start.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN; transitions IDLE->RUN on accepted start, RUN->DRAIN after last sample of last pass issued, DRAIN->IDLE on final LS eop.
REQ-020 start SHALL be accepted only in IDLE with legal num_ue, num_rx, len; these SHALL be latched on acceptance and ignored thereafter.
REQ-021 start in IDLE with any illegal field SHALL pulse err next cycle and remain IDLE.
REQ-022 start while busy SHALL be ignored and SHALL pulse err next cycle.
REQ-023 Pass order SHALL be UE outer, antenna inner: (ue0,ant0),(ue0,ant1),(ue1,ant0)...; total passes = num_ue*num_rx.
REQ-024 In RUN, buf_rd_en SHALL equal ls_sink_ready (combinational AND with state==RUN); address advances only on buf_rd_en.
REQ-025 buf_rd_addr SHALL run 0..len-1 per pass, wrapping to 0 at pass boundary with no idle cycle between passes.
REQ-026 Buffer read latency is 1 cycle; ls_valid SHALL be buf_rd_en delayed 1 cycle; ls_sop/ls_eop SHALL be registered alongside, marking addr 0 and addr len-1.
REQ-027 ue_idx and buf_ant SHALL be registered and aligned with ls_valid of the pass they belong to (change on the ls_sop cycle).
REQ-028 ls_sink_ready low SHALL freeze address, pass counter and outputs; ls_valid low the following cycle.
REQ-029 DRAIN SHALL count ls_source_valid&ls_source_eop; eop counter counts from acceptance (eops arriving during RUN counted).
REQ-030 When eop count reaches total passes, done SHALL pulse one cycle, busy falls same cycle, FSM to IDLE.
REQ-031 ls_source_eop without ls_source_valid SHALL be ignored; eops in IDLE ignored.
REQ-032 Counter widths: address wAddr+1, pass counter 3, eop counter 4; no overflow at legal config.

Reset
REQ-033 rst_n_sync low SHALL, on next clk edge, force IDLE and zero all outputs and counters, including mid-pass.
REQ-034 Reset values: buf_rd_en, ls_valid, ls_sop, ls_eop, busy, done, err = 0; buf_rd_addr, buf_ant, ue_idx = 0.

Structure
REQ-035 Shared package ce_pkg SHALL hold MAX_UE, FSM state encoding and legal-range constants.
REQ-036 One sub-module ce_ls_ctrl_addr_gen (address/pass/UE/antenna counters) SHALL be instantiated; FSM and drain counter stay in top.

Verification
REQ-037 num_ue=1,num_rx=1,len=12, ready=1 -> 12 ls_valid cycles, sop at addr0, eop at addr11, done 1 cycle after the looped-back eop.
REQ-038 num_ue=2,num_rx=2,len=4 -> 16 contiguous valids, (ue,ant) sequence 00,01,10,11 changing on sop, done after 4th eop.
REQ-039 Same as 038, ready low 3 cycles at addr 2 of pass 1 -> address held, no lost/duplicate samples, 16 valids total.
REQ-040 start with num_ue=0, then num_rx=3, then len=1 -> err pulse each, busy stays 0.
REQ-041 start during RUN -> err pulse, sequence unaffected; rst_n_sync low mid-pass -> all outputs 0 next cycle, new start runs cleanly.
